// File: rtl/pic_cmd_sequencer.sv
// pic_cmd_sequencer: synchronises PIC host bus strobes and decodes ICW1..ICW4 / OCW1..OCW3 into registers and strobes
module pic_cmd_sequencer #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IMR_RESET   = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              wr_n,
    input  logic              rd_n,
    input  logic              a0,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] icw1,
    output logic [DATA_W-1:0] icw2,
    output logic [DATA_W-1:0] icw3,
    output logic [DATA_W-1:0] icw4,
    output logic [DATA_W-1:0] ocw1,
    output logic [DATA_W-1:0] ocw2,
    output logic [DATA_W-1:0] ocw3,
    output logic              icw_done,
    output logic              init_busy,
    output logic              ocw1_wr,
    output logic              ocw2_wr,
    output logic              ocw3_wr,
    output logic              init_start,
    output logic              read_req,
    output logic              read_isr,
    output logic              poll_req,
    output logic              illegal_wr
);
    localparam logic [2:0]        S_UNINIT    = 3'd0;
    localparam logic [2:0]        S_WAIT_ICW2 = 3'd1;
    localparam logic [2:0]        S_WAIT_ICW3 = 3'd2;
    localparam logic [2:0]        S_WAIT_ICW4 = 3'd3;
    localparam logic [2:0]        S_READY     = 3'd4;
    localparam logic [DATA_W-1:0] OCW3_RESET  = DATA_W'(2);

    logic [SYNC_STAGES-1:0] r_wr_sync, r_rd_sync, r_cs_sync;
    logic                   r_wr_d, r_rd_d;
    logic                   r_cap_a0, r_cap_cs;
    logic [DATA_W-1:0]      r_cap_data;
    logic [2:0]             r_state;
    logic [DATA_W-1:0]      r_icw1, r_icw2, r_icw3, r_icw4, r_ocw1, r_ocw2, r_ocw3;
    logic                   r_poll;
    logic                   r_init_start, r_ocw1_wr, r_ocw2_wr, r_ocw3_wr, r_illegal_wr;
    logic                   r_read_req, r_poll_req, r_read_isr;

    logic              w_wr, w_rd, w_cs, w_wr_rise, w_commit, w_rd_evt, w_ready;
    logic              w_icw1_c, w_icw2_c, w_icw3_c, w_icw4_c;
    logic              w_ocw1_c, w_ocw2_c, w_ocw3_c, w_illegal_c;
    logic [DATA_W-1:0] w_ocw3_next;

    assign w_wr      = r_wr_sync[SYNC_STAGES-1];
    assign w_rd      = r_rd_sync[SYNC_STAGES-1];
    assign w_cs      = r_cs_sync[SYNC_STAGES-1];
    assign w_wr_rise = w_wr & ~r_wr_d;
    assign w_commit  = w_wr_rise & r_cap_cs;
    assign w_rd_evt  = ~w_rd & r_rd_d & ~w_cs;
    assign w_ready   = (r_state == S_READY);

    assign w_icw1_c    = w_commit & ~r_cap_a0 & r_cap_data[4];
    assign w_icw2_c    = w_commit & r_cap_a0 & (r_state == S_WAIT_ICW2);
    assign w_icw3_c    = w_commit & r_cap_a0 & (r_state == S_WAIT_ICW3);
    assign w_icw4_c    = w_commit & r_cap_a0 & (r_state == S_WAIT_ICW4);
    assign w_ocw1_c    = w_commit & r_cap_a0 & w_ready;
    assign w_ocw2_c    = w_commit & ~r_cap_a0 & ~r_cap_data[4] & ~r_cap_data[3] & w_ready;
    assign w_ocw3_c    = w_commit & ~r_cap_a0 & ~r_cap_data[4] & r_cap_data[3] & w_ready;
    assign w_illegal_c = w_commit & r_cap_a0 & (r_state == S_UNINIT);

    // OCW3 with RR=0 leaves the current IRR/ISR read selection in place
    assign w_ocw3_next = r_cap_data[1] ? r_cap_data : {r_cap_data[DATA_W-1:2], r_ocw3[1:0]};

    // Bring the host strobes into clk; idle-high reset means no edge is seen across reset release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_sync <= '1;
            r_rd_sync <= '1;
            r_cs_sync <= '1;
            r_wr_d    <= 1'b1;
            r_rd_d    <= 1'b1;
        end else begin
            r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], wr_n};
            r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], rd_n};
            r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_wr_d    <= w_wr;
            r_rd_d    <= w_rd;
        end
    end

    // Shadow a0/data while a selected write is low; remember the pulse was selected until its rising edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap_a0   <= 1'b0;
            r_cap_data <= '0;
            r_cap_cs   <= 1'b0;
        end else if (!w_wr && !w_cs) begin
            r_cap_a0   <= a0;
            r_cap_data <= data_in;
            r_cap_cs   <= 1'b1;
        end else if (w_wr_rise) begin
            r_cap_cs   <= 1'b0;
        end
    end

    // Initialisation state machine and command-word registers, updated on committed writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_UNINIT;
            r_icw1  <= '0;
            r_icw2  <= '0;
            r_icw3  <= '0;
            r_icw4  <= '0;
            r_ocw1  <= IMR_RESET;
            r_ocw2  <= '0;
            r_ocw3  <= OCW3_RESET;
        end else begin
            if (w_icw1_c) begin
                r_icw1  <= r_cap_data;
                r_ocw1  <= '0;
                r_ocw3  <= OCW3_RESET;
                r_state <= S_WAIT_ICW2;
            end
            if (w_icw2_c) begin
                r_icw2  <= r_cap_data;
                r_state <= !r_icw1[1] ? S_WAIT_ICW3 : r_icw1[0] ? S_WAIT_ICW4 : S_READY;
            end
            if (w_icw3_c) begin
                r_icw3  <= r_cap_data;
                r_icw4  <= r_icw1[0] ? r_icw4 : '0;
                r_state <= r_icw1[0] ? S_WAIT_ICW4 : S_READY;
            end
            if (w_icw4_c) begin
                r_icw4  <= r_cap_data;
                r_state <= S_READY;
            end
            if (w_ocw1_c) r_ocw1 <= r_cap_data;
            if (w_ocw2_c) r_ocw2 <= r_cap_data;
            if (w_ocw3_c) r_ocw3 <= w_ocw3_next;
        end
    end

    // Poll request is armed by OCW3 P=1 and consumed by the next read; ICW1 cancels it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_poll <= 1'b0;
        else if (w_icw1_c) r_poll <= 1'b0;
        else if (w_ocw3_c && r_cap_data[2]) r_poll <= 1'b1;
        else if (w_rd_evt) r_poll <= 1'b0;
    end

    // One-cycle strobes; read_isr samples the OCW3 value in force before any same-cycle OCW3 commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_init_start <= 1'b0;
            r_ocw1_wr    <= 1'b0;
            r_ocw2_wr    <= 1'b0;
            r_ocw3_wr    <= 1'b0;
            r_illegal_wr <= 1'b0;
            r_read_req   <= 1'b0;
            r_poll_req   <= 1'b0;
            r_read_isr   <= 1'b0;
        end else begin
            r_init_start <= w_icw1_c;
            r_ocw1_wr    <= w_ocw1_c;
            r_ocw2_wr    <= w_ocw2_c;
            r_ocw3_wr    <= w_ocw3_c;
            r_illegal_wr <= w_illegal_c;
            r_read_req   <= w_rd_evt & ~r_poll;
            r_poll_req   <= w_rd_evt & r_poll;
            r_read_isr   <= w_rd_evt ? r_ocw3[0] : r_read_isr;
        end
    end

    assign icw1       = r_icw1;
    assign icw2       = r_icw2;
    assign icw3       = r_icw3;
    assign icw4       = r_icw4;
    assign ocw1       = r_ocw1;
    assign ocw2       = r_ocw2;
    assign ocw3       = r_ocw3;
    assign icw_done   = w_ready;
    assign init_busy  = (r_state == S_WAIT_ICW2) | (r_state == S_WAIT_ICW3) | (r_state == S_WAIT_ICW4);
    assign ocw1_wr    = r_ocw1_wr;
    assign ocw2_wr    = r_ocw2_wr;
    assign ocw3_wr    = r_ocw3_wr;
    assign init_start = r_init_start;
    assign read_req   = r_read_req;
    assign read_isr   = r_read_isr;
    assign poll_req   = r_poll_req;
    assign illegal_wr = r_illegal_wr;
endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// tb_pic_cmd_sequencer: directed and random host bus transactions checked against a command-sequence model
module tb_pic_cmd_sequencer;
    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       reset, cs_n, wr_n, rd_n, a0;
    logic [7:0] data_in;
    logic [7:0] icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
    logic       icw_done, init_busy, ocw1_wr, ocw2_wr, ocw3_wr;
    logic       init_start, read_req, read_isr, poll_req, illegal_wr;

    int errors = 0;
    int checks = 0;

    int   c_init, c_o1, c_o2, c_o3, c_ill, c_rr, c_pr, lat;
    logic isr_seen;
    bit   e_init, e_o1, e_o2, e_o3, e_ill, e_rr, e_pr;
    logic e_isr;

    logic [7:0] m_icw1, m_icw2, m_icw3, m_icw4, m_ocw1, m_ocw2, m_ocw3;
    bit         m_poll, m_started;
    int         m_todo[$];

    always #5 clk = ~clk;

    pic_cmd_sequencer dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0), .data_in(data_in),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .ocw1(ocw1), .ocw2(ocw2), .ocw3(ocw3),
        .icw_done(icw_done), .init_busy(init_busy), .ocw1_wr(ocw1_wr), .ocw2_wr(ocw2_wr), .ocw3_wr(ocw3_wr),
        .init_start(init_start), .read_req(read_req), .read_isr(read_isr), .poll_req(poll_req),
        .illegal_wr(illegal_wr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_icw1 = 8'h00; m_icw2 = 8'h00; m_icw3 = 8'h00; m_icw4 = 8'h00;
        m_ocw1 = 8'hFF; m_ocw2 = 8'h00; m_ocw3 = 8'h02;
        m_poll = 0; m_started = 0;
        m_todo.delete();
    endtask

    task automatic clear_exp();
        e_init = 0; e_o1 = 0; e_o2 = 0; e_o3 = 0; e_ill = 0; e_rr = 0; e_pr = 0; e_isr = 1'b0;
    endtask

    task automatic model_write(input logic a, input logic [7:0] d, input logic c);
        int w;
        clear_exp();
        if (c) begin
        end else if (!a && d[4]) begin
            m_icw1 = d; m_ocw1 = 8'h00; m_ocw3 = 8'h02; m_poll = 0; m_started = 1;
            m_todo.delete();
            m_todo.push_back(2);
            if (!d[1]) m_todo.push_back(3);
            if (d[0]) m_todo.push_back(4);
            e_init = 1;
        end else if (a && m_todo.size() > 0) begin
            w = m_todo.pop_front();
            if (w == 2) m_icw2 = d;
            else if (w == 3) begin
                m_icw3 = d;
                if (!m_icw1[0]) m_icw4 = 8'h00;
            end else m_icw4 = d;
        end else if (m_started && m_todo.size() == 0) begin
            if (a) begin m_ocw1 = d; e_o1 = 1; end
            else if (!d[3]) begin m_ocw2 = d; e_o2 = 1; end
            else begin
                m_ocw3 = d[1] ? d : {d[7:2], m_ocw3[1:0]};
                if (d[2]) m_poll = 1;
                e_o3 = 1;
            end
        end else if (a && !m_started) e_ill = 1;
    endtask

    task automatic model_read(input logic c);
        clear_exp();
        if (!c) begin
            if (m_poll) begin e_pr = 1; m_poll = 0; end
            else begin e_rr = 1; e_isr = m_ocw3[0]; end
        end
    endtask

    task automatic tick(input int i);
        @(negedge clk);
        if ((init_start | ocw1_wr | ocw2_wr | ocw3_wr | illegal_wr | read_req | poll_req) && lat == 0) lat = i;
        if (init_start) c_init++;
        if (ocw1_wr) c_o1++;
        if (ocw2_wr) c_o2++;
        if (ocw3_wr) c_o3++;
        if (illegal_wr) c_ill++;
        if (poll_req) c_pr++;
        if (read_req) begin c_rr++; isr_seen = read_isr; end
    endtask

    task automatic clear_cnt();
        c_init = 0; c_o1 = 0; c_o2 = 0; c_o3 = 0; c_ill = 0; c_rr = 0; c_pr = 0; lat = 0; isr_seen = 1'bx;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".icw1"}, 32'(icw1), 32'(m_icw1));
        chk({tag, ".icw2"}, 32'(icw2), 32'(m_icw2));
        chk({tag, ".icw3"}, 32'(icw3), 32'(m_icw3));
        chk({tag, ".icw4"}, 32'(icw4), 32'(m_icw4));
        chk({tag, ".ocw1"}, 32'(ocw1), 32'(m_ocw1));
        chk({tag, ".ocw2"}, 32'(ocw2), 32'(m_ocw2));
        chk({tag, ".ocw3"}, 32'(ocw3), 32'(m_ocw3));
        chk({tag, ".icw_done"}, 32'(icw_done), 32'(m_started && m_todo.size() == 0));
        chk({tag, ".init_busy"}, 32'(init_busy), 32'(m_started && m_todo.size() != 0));
    endtask

    task automatic check_txn(input string tag);
        bit any;
        any = e_init | e_o1 | e_o2 | e_o3 | e_ill | e_rr | e_pr;
        chk({tag, ".init_start"}, 32'(c_init), 32'(e_init));
        chk({tag, ".ocw1_wr"}, 32'(c_o1), 32'(e_o1));
        chk({tag, ".ocw2_wr"}, 32'(c_o2), 32'(e_o2));
        chk({tag, ".ocw3_wr"}, 32'(c_o3), 32'(e_o3));
        chk({tag, ".illegal_wr"}, 32'(c_ill), 32'(e_ill));
        chk({tag, ".read_req"}, 32'(c_rr), 32'(e_rr));
        chk({tag, ".poll_req"}, 32'(c_pr), 32'(e_pr));
        chk({tag, ".latency"}, 32'(lat), any ? 32'(LAT) : 32'd0);
        if (e_rr) chk({tag, ".read_isr"}, 32'(isr_seen), 32'(e_isr));
        check_regs(tag);
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d, input logic c, input string tag);
        model_write(a, d, c);
        @(negedge clk);
        a0 = a; data_in = d; cs_n = c; wr_n = 1'b0;
        clear_cnt();
        repeat (4) tick(-1);
        wr_n = 1'b1;
        for (int i = 1; i <= 8; i++) tick(i);
        cs_n = 1'b1;
        check_txn(tag);
    endtask

    task automatic bus_read(input logic c, input string tag);
        model_read(c);
        @(negedge clk);
        cs_n = c; rd_n = 1'b0;
        clear_cnt();
        for (int i = 1; i <= 10; i++) begin
            tick(i);
            if (i == 4) rd_n = 1'b1;
        end
        cs_n = 1'b1;
        check_txn(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r;
        reset = 1'b1; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; a0 = 1'b0; data_in = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check_regs("reset");
        chk("reset.strobes", 32'({init_start, ocw1_wr, ocw2_wr, ocw3_wr, illegal_wr, read_req, poll_req}), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        bus_write(1'b1, 8'h55, 1'b0, "uninit_a0");
        bus_write(1'b0, 8'h13, 1'b1, "cs_high");
        bus_read(1'b0, "uninit_read");

        bus_write(1'b0, 8'h13, 1'b0, "sngl.icw1");
        bus_write(1'b1, 8'h20, 1'b0, "sngl.icw2");
        bus_write(1'b1, 8'h01, 1'b0, "sngl.icw4");

        bus_write(1'b0, 8'h11, 1'b0, "casc.icw1");
        bus_write(1'b1, 8'h08, 1'b0, "casc.icw2");
        bus_write(1'b1, 8'h04, 1'b0, "casc.icw3");
        bus_write(1'b1, 8'h1D, 1'b0, "casc.icw4");

        bus_write(1'b1, 8'hFB, 1'b0, "ocw1");
        bus_write(1'b0, 8'h20, 1'b0, "ocw2");
        bus_write(1'b0, 8'h0B, 1'b0, "ocw3_isr");
        bus_read(1'b0, "read_isr");
        bus_write(1'b0, 8'h0C, 1'b0, "ocw3_poll");
        bus_read(1'b0, "poll_read");
        bus_read(1'b0, "after_poll");
        bus_read(1'b1, "read_cs_high");

        bus_write(1'b0, 8'h11, 1'b0, "restart.icw1");
        bus_write(1'b1, 8'h08, 1'b0, "restart.icw2");
        bus_write(1'b0, 8'h13, 1'b0, "restart.again");
        bus_write(1'b0, 8'h05, 1'b0, "wait.ignored");
        bus_write(1'b1, 8'h40, 1'b0, "restart.icw2b");

        bus_write(1'b0, 8'h11, 1'b0, "rst.icw1");
        bus_write(1'b1, 8'h08, 1'b0, "rst.icw2");
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_regs("async_reset");
        chk("async_reset.strobes", 32'({init_start, ocw1_wr, ocw2_wr, ocw3_wr, illegal_wr, read_req, poll_req}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        bus_write(1'b1, 8'h77, 1'b0, "post_reset_a0");

        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            if (r < 3) bus_read($urandom_range(0, 7) == 0, "rnd_rd");
            else if (r < 5) bus_write(1'b0, 8'($urandom) & 8'hEF, $urandom_range(0, 9) == 0, "rnd_ocw");
            else bus_write(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 9) == 0, "rnd_wr");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
